// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit: data bus, register index and write request.
package writeback_unit_pkg;

    localparam int unsigned BUS_WIDTH = 32;
    localparam int unsigned REG_COUNT = 32;

    typedef logic [BUS_WIDTH-1:0] bus_type;
    typedef logic [4:0]           reg_idx_type;

    typedef struct packed {
        reg_idx_type rd;
        bus_type     data;
    } wb_req_type;

endpackage

// File: rtl/writeback_unit_sync_fifo.sv
// Single-clock FIFO with registered storage; full is judged from the pointers alone,
// so a full FIFO refuses a push even in a cycle where it pops.
module writeback_unit_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_data_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        // Extra pointer bit distinguishes full from empty when the indices match.
        full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o     = (wr_ptr_q == rd_ptr_q);
        push_ok     = push_i && !full_o;
        pop_ok      = pop_i && !empty_o;
        head_data_o = mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop_ok);
        mem_d       = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results onto the register file write port and tracks
// outstanding writes per register for hazard detection at issue.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned MEM_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  bus_type     alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  bus_type     mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy_mask,
    output logic        rf_write_en,
    output logic [5:0]  rf_write_addr,
    output bus_type     rf_write_data
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    wb_req_type fifo_head;
    wb_req_type win_req;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic       force_alu, win_valid;

    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                 wr_en_q, wr_en_d;
    reg_idx_type          wr_addr_q, wr_addr_d;
    bus_type              wr_data_q, wr_data_d;
    logic [REG_COUNT-1:0] busy_q, busy_d;

    writeback_unit_sync_fifo #(
        .WIDTH ($bits(wb_req_type)),
        .DEPTH (MEM_FIFO_DEPTH)
    ) u_mem_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({mem_rd, mem_data}),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_data_o (fifo_head)
    );

    always_comb begin
        force_alu = alu_valid && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        fifo_pop  = !rst && !fifo_empty && !force_alu;
        alu_ready = !rst && alu_valid && !fifo_pop;
        mem_ready = !rst && !fifo_full;
        fifo_push = mem_valid && mem_ready;

        win_valid = fifo_pop || alu_ready;
        win_req   = fifo_pop ? fifo_head : '{rd: alu_rd, data: alu_data};

        // x0 winners complete the handshake but never reach the file.
        wr_en_d   = win_valid && (win_req.rd != '0);
        wr_addr_d = wr_en_d ? win_req.rd : wr_addr_q;
        wr_data_d = wr_en_d ? win_req.data : wr_data_q;

        starve_cnt_d = starve_cnt_q;
        if (!alu_valid || alu_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        // Clear first so a same-edge set of the same register wins.
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_write_en   = wr_en_q;
    assign rf_write_addr = {1'b0, wr_addr_q};
    assign rf_write_data = wr_data_q;
    assign busy_mask     = busy_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: one instance with default starvation limit and one
// with limit 0 (ALU always wins) so the load FIFO can be filled and held.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        alu_valid = 0, mem_valid = 0, issue_valid = 0;
    logic [4:0]  alu_rd = 0, mem_rd = 0, issue_rd = 0;
    bus_type     alu_data = 0, mem_data = 0;
    logic        alu_ready, mem_ready, rf_write_en;
    logic [31:0] busy_mask;
    logic [5:0]  rf_write_addr;
    bus_type     rf_write_data;

    logic        f_alu_valid = 0, f_mem_valid = 0, f_issue_valid = 0;
    logic [4:0]  f_alu_rd = 0, f_mem_rd = 0, f_issue_rd = 0;
    bus_type     f_alu_data = 0, f_mem_data = 0;
    logic        f_alu_ready, f_mem_ready, f_rf_write_en;
    logic [31:0] f_busy_mask;
    logic [5:0]  f_rf_write_addr;
    bus_type     f_rf_write_data;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    writeback_unit #(.MEM_FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk (clk), .rst (rst),
        .alu_valid (alu_valid), .alu_rd (alu_rd), .alu_data (alu_data), .alu_ready (alu_ready),
        .mem_valid (mem_valid), .mem_rd (mem_rd), .mem_data (mem_data), .mem_ready (mem_ready),
        .issue_valid (issue_valid), .issue_rd (issue_rd), .busy_mask (busy_mask),
        .rf_write_en (rf_write_en), .rf_write_addr (rf_write_addr), .rf_write_data (rf_write_data)
    );

    writeback_unit #(.MEM_FIFO_DEPTH(4), .STARVE_LIMIT(0)) dut_f (
        .clk (clk), .rst (rst),
        .alu_valid (f_alu_valid), .alu_rd (f_alu_rd), .alu_data (f_alu_data),
        .alu_ready (f_alu_ready),
        .mem_valid (f_mem_valid), .mem_rd (f_mem_rd), .mem_data (f_mem_data),
        .mem_ready (f_mem_ready),
        .issue_valid (f_issue_valid), .issue_rd (f_issue_rd), .busy_mask (f_busy_mask),
        .rf_write_en (f_rf_write_en), .rf_write_addr (f_rf_write_addr),
        .rf_write_data (f_rf_write_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle boundary: 1 time unit after the active edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("rst_en", rf_write_en, 0);
        chk("rst_addr", rf_write_addr, 0);
        chk("rst_data", rf_write_data, 0);
        chk("rst_busy", busy_mask, 0);
        alu_valid = 1;
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        alu_valid = 0;
        @(negedge clk);
        rst = 0;

        // ALU only, with a prior issue to r5
        next();
        chk("pre_busy5", busy_mask[5], 0);
        issue_valid = 1; issue_rd = 5;
        next();
        issue_valid = 0;
        chk("busy5_set", busy_mask, 32'h0000_0020);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD;
        #1 chk("alu_ready_c0", alu_ready, 1);
        next();
        alu_valid = 0;
        chk("alu_wr_en", rf_write_en, 1);
        chk("alu_wr_addr", rf_write_addr, 5);
        chk("alu_wr_data", rf_write_data, 32'hDEAD);
        chk("busy5_held_c1", busy_mask, 32'h0000_0020);
        next();
        chk("busy5_clear_c2", busy_mask, 0);
        chk("alu_wr_done", rf_write_en, 0);

        // Load priority and 2-cycle latency
        mem_valid = 1; mem_rd = 7; mem_data = 32'h1234;
        #1 chk("ld_mem_ready", mem_ready, 1);
        next();
        mem_valid = 0;
        alu_valid = 1; alu_rd = 4; alu_data = 32'hAAAA;
        chk("ld_no_write_c1", rf_write_en, 0);
        #1 chk("ld_alu_waits", alu_ready, 0);
        next();
        chk("ld_wr_en_c2", rf_write_en, 1);
        chk("ld_wr_addr_c2", rf_write_addr, 7);
        chk("ld_wr_data_c2", rf_write_data, 32'h1234);
        #1 chk("ld_alu_granted", alu_ready, 1);
        next();
        alu_valid = 0;
        chk("ld_alu_wr_addr", rf_write_addr, 4);
        chk("ld_alu_wr_data", rf_write_data, 32'hAAAA);
        next();
        chk("ld_idle", rf_write_en, 0);

        // Starvation: loads keep the FIFO non-empty while the ALU waits
        mem_valid = 1; mem_rd = 10; mem_data = 32'h110;
        for (int k = 0; k < 4; k++) begin
            next();
            if (k > 0) begin
                chk("stv_ld_addr", rf_write_addr, 6'(9 + k));
                chk("stv_ld_en", rf_write_en, 1);
            end
            mem_rd = 5'(11 + k); mem_data = 32'(32'h111 + k);
            alu_valid = 1; alu_rd = 3; alu_data = 32'h333;
            #1 chk("stv_alu_ready", alu_ready, (k == 3) ? 1 : 0);
        end
        next();
        mem_valid = 0; alu_valid = 0;
        chk("stv_forced_addr", rf_write_addr, 3);
        chk("stv_forced_data", rf_write_data, 32'h333);
        next();
        chk("stv_drain13", rf_write_data, 32'h113);
        next();
        chk("stv_drain14", rf_write_addr, 14);
        next();
        chk("stv_idle", rf_write_en, 0);

        // x0 write and issue to a register committing this cycle
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
        #1 chk("x0_ready", alu_ready, 1);
        next();
        chk("x0_no_write", rf_write_en, 0);
        alu_rd = 9; alu_data = 32'h99;
        next();
        alu_valid = 0;
        chk("r9_wr_addr", rf_write_addr, 9);
        chk("pre_busy9", busy_mask[9], 0);
        issue_valid = 1; issue_rd = 9;
        next();
        issue_valid = 0;
        chk("busy9_set_wins", busy_mask, 32'h0000_0200);

        // FIFO full on the always-ALU instance
        for (int k = 0; k < 4; k++) begin
            next();
            f_alu_valid = 1; f_alu_rd = 0;
            f_mem_valid = 1; f_mem_rd = 5'(20 + k); f_mem_data = 32'(32'h120 + k);
            #1 chk("full_ready_fill", f_mem_ready, 1);
        end
        next();
        f_mem_rd = 24; f_mem_data = 32'h124;
        #1 chk("full_ready_c4", f_mem_ready, 0);
        next();
        f_alu_valid = 0;
        #1 chk("full_ready_pop", f_mem_ready, 0);
        next();
        chk("full_wr_addr", f_rf_write_addr, 20);
        chk("full_wr_data", f_rf_write_data, 32'h120);
        #1 chk("full_ready_back", f_mem_ready, 1);

        // Park 3 entries, mark r8/r9 busy, then reset asynchronously
        next();
        f_mem_valid = 0; f_alu_valid = 1; f_alu_rd = 0;
        chk("park_wr_addr", f_rf_write_addr, 21);
        chk("pre_busy8", f_busy_mask[8], 0);
        f_issue_valid = 1; f_issue_rd = 8;
        next();
        chk("park_x0", f_rf_write_en, 0);
        chk("pre_busy9_f", f_busy_mask[9], 0);
        f_issue_rd = 9; f_alu_rd = 2; f_alu_data = 32'h22;
        next();
        f_issue_valid = 0; f_alu_rd = 5; f_alu_data = 32'h55;
        chk("park_busy", f_busy_mask, 32'h0000_0300);
        chk("park_wr_en", f_rf_write_en, 1);
        #3 rst = 1;
        #1;
        chk("arst_en", f_rf_write_en, 0);
        chk("arst_addr", f_rf_write_addr, 0);
        chk("arst_data", f_rf_write_data, 0);
        chk("arst_busy", f_busy_mask, 0);
        chk("arst_busy_main", busy_mask, 0);
        chk("arst_alu_ready", f_alu_ready, 0);
        chk("arst_mem_ready", f_mem_ready, 0);
        f_alu_valid = 0;
        next();
        chk("arst_hold_en", f_rf_write_en, 0);
        @(negedge clk);
        rst = 0;
        next();
        chk("post_rst_no_wr", f_rf_write_en, 0);
        next();
        chk("post_rst_fifo_empty", f_rf_write_en, 0);
        chk("post_rst_mem_ready", f_mem_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
